st7789_panel_rx: RTL and testbench
==================================

# st7789_panel_rx

SPI-slave model of the ST7789 panel's write path: receives the 4-wire (CS/SCK/MOSI/DC) byte stream that our display driver emits. It decodes CASET/RASET/RAMWR, tracks the address window and writes RGB565 pixels into a frame-buffer port. It sits at the far end of the display SPI link, both in the loopback test harness and as a frame-capture block on the debug board.

## Interface
Parameters:
- SCREEN_W, 240, panel width in pixels
- SCREEN_H, 320, panel height in pixels
- ADDR_W, 17, frame-buffer address width; must satisfy 2^ADDR_W ≥ SCREEN_W*SCREEN_H

Ports:
- clk  in  1  system clock; must be ≥ 4× SCK frequency
- rst_n  in  1  reset, asynchronous, active-low
- spi_cs  in  1  chip select, active-low; asynchronous to clk
- spi_sck  in  1  SPI clock, mode 0; MOSI is sampled on the rising edge
- spi_mosi  in  1  serial data, MSB first
- spi_dc  in  1  0 = command byte, 1 = data byte; sampled together with the 8th bit
- fb_we  out  1  frame-buffer write strobe, one cycle per pixel
- fb_addr  out  ADDR_W  pixel address, y*SCREEN_W + x
- fb_data  out  16  RGB565 pixel, first byte received is [15:8]
- cmd_strobe  out  1  one-cycle pulse for each received command byte
- cmd_code  out  8  last command byte; holds its value between strobes
- frame_done  out  1  one-cycle pulse, coincident with the fb_we that writes pixel (XE,YE)

## Operation
- Input conditioning: spi_cs, spi_sck, spi_mosi and spi_dc each pass through a 2-FF synchronizer.
  - SCK rising edge is detected on the synchronized signal.
  - While CS is high, the bit counter is held at 0.
- Byte assembly: 8 rising edges shift MOSI in MSB first. On the 8th edge the block emits an internal byte_valid with {dc, byte}, and the bit counter returns to 0.
- Window registers XS, XE, YS, YE (9 bits each).
  - Reset values: 0, SCREEN_W-1, 0, SCREEN_H-1.
  - XE is clamped to SCREEN_W-1 and YE to SCREEN_H-1.
  - If a start value exceeds its end, the start is forced equal to the end.
  - Parameters are 16-bit big-endian.
  - New values commit only when the 4th parameter byte arrives; a partial parameter set is discarded.
- FSM states: S_IDLE, S_CASET, S_RASET, S_RAMWR, S_SKIP.
- Every command byte, in any state:
  - cmd_strobe pulses and cmd_code updates.
  - 0x2A → S_CASET, 0x2B → S_RASET, 0x2C → S_RAMWR, any other code → S_SKIP.
  - The parameter index and the pixel byte phase are cleared.
- S_CASET / S_RASET:
  - Data bytes fill parameter index 0..3.
  - After index 3 the window commits and the FSM goes to S_IDLE.
- S_RAMWR:
  - Entry sets the pointer to (XS,YS).
  - Even data bytes load the high byte; odd data bytes complete a pixel and write it.
  - After each write, x increments. At x==XE, x wraps to XS and y increments. At y==YE, y wraps to YS and frame_done pulses.
  - Writing continues indefinitely.
- S_SKIP and S_IDLE: data bytes are ignored.
- CS rising edge, synchronized:
  - Discards any partial byte and a pending high pixel byte.
  - FSM returns to S_IDLE; window registers are kept.

## Timing
- Reset values: all outputs 0, FSM in S_IDLE, window at full screen.
- Latency from pin to byte_valid: 2 sync cycles + 1 edge-detect cycle + 1 register cycle after the 8th SCK rising edge.
- fb_we, fb_addr and fb_data are registered together, asserted the cycle after the low byte's byte_valid, and held for exactly 1 cycle. fb_addr and fb_data hold their values afterwards.
- cmd_strobe is asserted the cycle after byte_valid.
- A command byte's own cmd_strobe and any pending fb_we can never coincide, because bytes are at least 32 clk apart.
- Address arithmetic: fb_addr = y*SCREEN_W + x. It is computed in ADDR_W bits, combinationally from registered x/y, and registered into the output.
- Reset asserted mid-byte or mid-pixel returns the block to the reset state immediately; no fb_we is produced.

## Structure
- Package st7789_pkg:
  - CMD_CASET = 8'h2A, CMD_RASET = 8'h2B, CMD_RAMWR = 8'h2C.
  - The rx_state_t enum.
  - SCREEN_W/SCREEN_H defaults; the driver also uses these.
- Sub-module spi_byte_rx: synchronizers, SCK edge detect and shifter. Outputs byte_valid, byte_data[7:0] and byte_dc, plus a cs_rise pulse.
- Top level: command FSM, window registers, pixel pointer and frame-buffer output register.

## Test plan
- Reset, then RAMWR followed by data bytes 0x12, 0x34 → one fb_we with addr 0 and data 0x1234; cmd_code = 0x2C.
- CASET 0,10,0,11; RASET 0,5,0,6; RAMWR; 4 pixels → fb_addr sequence 1210, 1211, 1450, 1451; frame_done pulses on the 4th write.
- A 5th pixel in the same RAMWR → addr 1210, confirming wrap to (XS,YS).
- CASET with XS = 300, XE = 400 → window becomes XS = XE = 239; RAMWR with 2 pixels writes addr 239 then 479.
- CS raised after 5 bits and again after one pixel high byte → no fb_we; the next full byte decodes correctly.
- CASET with only 2 parameters, then RAMWR → window unchanged (full screen); first pixel goes to addr 0.

Source files
------------

// File: rtl/st7789_pkg.sv
// st7789_pkg: shared command codes, panel geometry defaults and receiver state type
package st7789_pkg;

    localparam int DEFAULT_SCREEN_W = 240;
    localparam int DEFAULT_SCREEN_H = 320;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CASET,
        S_RASET,
        S_RAMWR,
        S_SKIP
    } rx_state_t;

    // Saturate a 16-bit window coordinate to a 9-bit limit.
    function automatic logic [8:0] clamp9(input logic [15:0] v, input logic [8:0] lim);
        return (v > {7'd0, lim}) ? lim : v[8:0];
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronizes the SPI pins, detects SCK rising edges and assembles bytes
module spi_byte_rx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       spi_cs_i,
    input  logic       spi_sck_i,
    input  logic       spi_mosi_i,
    input  logic       spi_dc_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       byte_dc_o,
    output logic       cs_rise_o
);

    logic [1:0] cs_sync_q, sck_sync_q, mosi_sync_q, dc_sync_q;
    logic       sck_prev_q, cs_prev_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       byte_valid_q, byte_valid_d;
    logic [7:0] byte_data_q, byte_data_d;
    logic       byte_dc_q, byte_dc_d;
    logic       cs_rise_q, cs_rise_d;
    logic       cs_s, sck_rise;

    assign cs_s     = cs_sync_q[1];
    assign sck_rise = sck_sync_q[1] & ~sck_prev_q & ~cs_s;

    // Shift on each SCK rise while selected; the 8th rise completes a byte.
    always_comb begin
        bit_cnt_d    = cs_s ? 3'd0 : (sck_rise ? bit_cnt_q + 3'd1 : bit_cnt_q);
        shift_d      = sck_rise ? {shift_q[5:0], mosi_sync_q[1]} : shift_q;
        byte_valid_d = sck_rise & (bit_cnt_q == 3'd7);
        byte_data_d  = byte_valid_d ? {shift_q, mosi_sync_q[1]} : byte_data_q;
        byte_dc_d    = byte_valid_d ? dc_sync_q[1] : byte_dc_q;
        cs_rise_d    = cs_s & ~cs_prev_q;
    end

    // Synchronizers, edge-detect history and byte output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q    <= 2'b11;
            sck_sync_q   <= 2'b00;
            mosi_sync_q  <= 2'b00;
            dc_sync_q    <= 2'b00;
            sck_prev_q   <= 1'b0;
            cs_prev_q    <= 1'b1;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 7'd0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'd0;
            byte_dc_q    <= 1'b0;
            cs_rise_q    <= 1'b0;
        end else begin
            cs_sync_q    <= {cs_sync_q[0], spi_cs_i};
            sck_sync_q   <= {sck_sync_q[0], spi_sck_i};
            mosi_sync_q  <= {mosi_sync_q[0], spi_mosi_i};
            dc_sync_q    <= {dc_sync_q[0], spi_dc_i};
            sck_prev_q   <= sck_sync_q[1];
            cs_prev_q    <= cs_s;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            byte_dc_q    <= byte_dc_d;
            cs_rise_q    <= cs_rise_d;
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign byte_dc_o    = byte_dc_q;
    assign cs_rise_o    = cs_rise_q;

endmodule

// File: rtl/st7789_panel_rx.sv
// st7789_panel_rx: ST7789 write-path decoder driving a frame-buffer write port
module st7789_panel_rx
    import st7789_pkg::*;
#(
    parameter int SCREEN_W = DEFAULT_SCREEN_W,
    parameter int SCREEN_H = DEFAULT_SCREEN_H,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_cs,
    input  logic              spi_sck,
    input  logic              spi_mosi,
    input  logic              spi_dc,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    output logic              cmd_strobe,
    output logic [7:0]        cmd_code,
    output logic              frame_done
);

    localparam logic [8:0] XMAX = 9'(SCREEN_W - 1);
    localparam logic [8:0] YMAX = 9'(SCREEN_H - 1);

    logic        byte_valid, byte_dc, cs_rise;
    logic [7:0]  byte_data;

    rx_state_t   state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
    logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [15:0]       fb_data_q, fb_data_d;
    logic        cmd_strobe_q, cmd_strobe_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        frame_done_q, frame_done_d;

    logic [8:0]        end_c, start_c;
    logic [ADDR_W-1:0] addr_c;
    logic              x_end, y_end;

    spi_byte_rx u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_cs_i     (spi_cs),
        .spi_sck_i    (spi_sck),
        .spi_mosi_i   (spi_mosi),
        .spi_dc_i     (spi_dc),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .byte_dc_o    (byte_dc),
        .cs_rise_o    (cs_rise)
    );

    assign end_c   = clamp9({p2_q, byte_data}, (state_q == S_CASET) ? XMAX : YMAX);
    assign start_c = clamp9({p0_q, p1_q}, end_c);
    assign addr_c  = ADDR_W'(y_q) * ADDR_W'(SCREEN_W) + ADDR_W'(x_q);
    assign x_end   = (x_q == xe_q);
    assign y_end   = (y_q == ye_q);

    // Command decode, window parameter capture and pixel assembly.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        p0_d         = p0_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        x_d          = x_q;
        y_d          = y_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        fb_we_d      = 1'b0;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        cmd_strobe_d = 1'b0;
        cmd_code_d   = cmd_code_q;
        frame_done_d = 1'b0;
        if (cs_rise) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            phase_d = 1'b0;
        end else if (byte_valid && !byte_dc) begin
            cmd_strobe_d = 1'b1;
            cmd_code_d   = byte_data;
            idx_d        = 2'd0;
            phase_d      = 1'b0;
            x_d          = xs_q;
            y_d          = ys_q;
            state_d      = (byte_data == CMD_CASET) ? S_CASET :
                           (byte_data == CMD_RASET) ? S_RASET :
                           (byte_data == CMD_RAMWR) ? S_RAMWR : S_SKIP;
        end else if (byte_valid && (state_q == S_CASET || state_q == S_RASET)) begin
            idx_d = idx_q + 2'd1;
            p0_d  = (idx_q == 2'd0) ? byte_data : p0_q;
            p1_d  = (idx_q == 2'd1) ? byte_data : p1_q;
            p2_d  = (idx_q == 2'd2) ? byte_data : p2_q;
            if (idx_q == 2'd3) begin
                state_d = S_IDLE;
                xs_d    = (state_q == S_CASET) ? start_c : xs_q;
                xe_d    = (state_q == S_CASET) ? end_c : xe_q;
                ys_d    = (state_q == S_RASET) ? start_c : ys_q;
                ye_d    = (state_q == S_RASET) ? end_c : ye_q;
            end
        end else if (byte_valid && state_q == S_RAMWR) begin
            phase_d = ~phase_q;
            hi_d    = phase_q ? hi_q : byte_data;
            if (phase_q) begin
                fb_we_d      = 1'b1;
                fb_addr_d    = addr_c;
                fb_data_d    = {hi_q, byte_data};
                frame_done_d = x_end & y_end;
                x_d          = x_end ? xs_q : x_q + 9'd1;
                y_d          = x_end ? (y_end ? ys_q : y_q + 9'd1) : y_q;
            end
        end
    end

    // State, window and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            p0_q         <= 8'd0;
            p1_q         <= 8'd0;
            p2_q         <= 8'd0;
            xs_q         <= 9'd0;
            xe_q         <= XMAX;
            ys_q         <= 9'd0;
            ye_q         <= YMAX;
            x_q          <= 9'd0;
            y_q          <= 9'd0;
            phase_q      <= 1'b0;
            hi_q         <= 8'd0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= 16'd0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            p0_q         <= p0_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            x_q          <= x_d;
            y_q          <= y_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            cmd_strobe_q <= cmd_strobe_d;
            cmd_code_q   <= cmd_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_we      = fb_we_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign cmd_strobe = cmd_strobe_q;
    assign cmd_code   = cmd_code_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_st7789_panel_rx.sv
// tb_st7789_panel_rx: drives SPI byte streams and checks frame-buffer writes against a window model
module tb_st7789_panel_rx;

    localparam int W = 240;
    localparam int H = 320;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_dc = 1'b0;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [15:0] fb_data;
    logic        cmd_strobe;
    logic [7:0]  cmd_code;
    logic        frame_done;

    always #5 clk = ~clk;

    st7789_panel_rx #(.SCREEN_W(W), .SCREEN_H(H), .ADDR_W(17)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_cs     (spi_cs),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_dc     (spi_dc),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_data    (fb_data),
        .cmd_strobe (cmd_strobe),
        .cmd_code   (cmd_code),
        .frame_done (frame_done)
    );

    typedef struct {
        int addr;
        int data;
        int fd;
    } wr_t;

    typedef struct {
        int xs, xe, ys, ye;
        int npix;
        int addr0, addr_last, frames;
    } vec_t;

    wr_t        got_q[$];
    wr_t        exp_q[$];
    logic [7:0] got_cmd[$];
    logic [7:0] exp_cmd[$];
    int         stray_fd = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         mxs = 0, mxe = W - 1, mys = 0, mye = H - 1, mk = 0;
    vec_t       tbl[4];

    // Record every write and command strobe away from the active edge.
    always @(negedge clk) begin
        if (fb_we) got_q.push_back('{int'(fb_addr), int'(fb_data), int'(frame_done)});
        else if (frame_done) stray_fd++;
        if (cmd_strobe) got_cmd.push_back(cmd_code);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_bits(input logic dc, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            spi_dc   = dc;
            spi_sck  = 1'b0;
            #40;
            spi_sck  = 1'b1;
            #40;
        end
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_bits(dc, b, 8);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        send_byte(1'b0, c);
        exp_cmd.push_back(c);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        #100;
    endtask

    task automatic cs_high();
        #40;
        spi_sck = 1'b0;
        spi_cs  = 1'b1;
        #200;
    endtask

    // Closed-form position of the k-th pixel of a RAMWR burst inside the window.
    task automatic model_pixel(input int data);
        int wc, wr, k;
        wc = mxe - mxs + 1;
        wr = mye - mys + 1;
        k  = mk % (wc * wr);
        exp_q.push_back('{(mys + k / wc) * W + mxs + k % wc, data, int'(k == wc * wr - 1)});
        mk++;
    endtask

    task automatic send_pixel(input logic [15:0] d);
        send_byte(1'b1, d[15:8]);
        send_byte(1'b1, d[7:0]);
        model_pixel(int'(d));
    endtask

    task automatic ramwr(input int n);
        send_cmd(8'h2C);
        mk = 0;
        for (int i = 0; i < n; i++) send_pixel(16'($urandom_range(0, 65535)));
    endtask

    task automatic set_win(input int xs, input int xe, input int ys, input int ye);
        logic [15:0] v;
        send_cmd(8'h2A);
        v = 16'(xs); send_byte(1'b1, v[15:8]); send_byte(1'b1, v[7:0]);
        v = 16'(xe); send_byte(1'b1, v[15:8]); send_byte(1'b1, v[7:0]);
        send_cmd(8'h2B);
        v = 16'(ys); send_byte(1'b1, v[15:8]); send_byte(1'b1, v[7:0]);
        v = 16'(ye); send_byte(1'b1, v[15:8]); send_byte(1'b1, v[7:0]);
        mxe = (xe > W - 1) ? W - 1 : xe;
        mxs = (xs > mxe) ? mxe : xs;
        mye = (ye > H - 1) ? H - 1 : ye;
        mys = (ys > mye) ? mye : ys;
    endtask

    task automatic compare_all(input string name);
        int n;
        #400;
        check({name, " write count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s addr[%0d]", name, i), got_q[i].addr, exp_q[i].addr);
            check($sformatf("%s data[%0d]", name, i), got_q[i].data, exp_q[i].data);
            check($sformatf("%s frame_done[%0d]", name, i), got_q[i].fd, exp_q[i].fd);
        end
        check({name, " cmd count"}, got_cmd.size(), exp_cmd.size());
        n = (got_cmd.size() < exp_cmd.size()) ? got_cmd.size() : exp_cmd.size();
        for (int i = 0; i < n; i++) check($sformatf("%s cmd[%0d]", name, i), got_cmd[i], exp_cmd[i]);
        got_q.delete();
        exp_q.delete();
        got_cmd.delete();
        exp_cmd.delete();
    endtask

    initial begin
        int frames;
        tbl[0] = '{10, 11, 5, 6, 5, 1210, 1210, 1};
        tbl[1] = '{300, 400, 0, 319, 2, 239, 479, 0};
        tbl[2] = '{0, 239, 319, 500, 3, 76560, 76562, 0};
        tbl[3] = '{238, 239, 318, 319, 4, 76558, 76799, 1};

        repeat (4) @(negedge clk);
        check("reset fb_we", fb_we, 0);
        check("reset fb_addr", fb_addr, 0);
        check("reset fb_data", fb_data, 0);
        check("reset cmd_strobe", cmd_strobe, 0);
        check("reset cmd_code", cmd_code, 0);
        check("reset frame_done", frame_done, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        cs_low();
        send_cmd(8'h2C);
        mk = 0;
        send_pixel(16'h1234);
        cs_high();
        check("basic cmd_code", cmd_code, 8'h2C);
        compare_all("basic");

        foreach (tbl[v]) begin
            cs_low();
            set_win(tbl[v].xs, tbl[v].xe, tbl[v].ys, tbl[v].ye);
            ramwr(tbl[v].npix);
            cs_high();
            #400;
            frames = 0;
            foreach (got_q[i]) frames += got_q[i].fd;
            check($sformatf("vec%0d first addr", v), (got_q.size() > 0) ? got_q[0].addr : -1, tbl[v].addr0);
            check($sformatf("vec%0d last addr", v), (got_q.size() > 0) ? got_q[got_q.size() - 1].addr : -1, tbl[v].addr_last);
            check($sformatf("vec%0d frames", v), frames, tbl[v].frames);
            compare_all($sformatf("vec%0d", v));
        end

        for (int r = 0; r < 6; r++) begin
            cs_low();
            set_win($urandom_range(0, 260), $urandom_range(0, 260), $urandom_range(0, 340), $urandom_range(0, 340));
            ramwr($urandom_range(1, 8));
            cs_high();
            compare_all($sformatf("rand%0d", r));
        end

        cs_low();
        send_bits(1'b0, 8'h2A, 5);
        cs_high();
        cs_low();
        send_cmd(8'h2C);
        send_byte(1'b1, 8'h99);
        cs_high();
        cs_low();
        send_byte(1'b1, 8'hAA);
        send_byte(1'b1, 8'hBB);
        send_cmd(8'h2C);
        mk = 0;
        send_pixel(16'h5678);
        cs_high();
        compare_all("cs_abort");

        cs_low();
        set_win(0, 239, 0, 319);
        send_cmd(8'h2A);
        send_byte(1'b1, 8'h00);
        send_byte(1'b1, 8'h50);
        send_cmd(8'h2C);
        mk = 0;
        send_pixel(16'hBEEF);
        cs_high();
        compare_all("partial_caset");

        cs_low();
        set_win(5, 9, 7, 8);
        send_cmd(8'h2C);
        send_byte(1'b1, 8'hAB);
        send_bits(1'b1, 8'hCD, 4);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset fb_we", fb_we, 0);
        check("midreset cmd_code", cmd_code, 0);
        check("midreset fb_addr", fb_addr, 0);
        cs_high();
        rst_n = 1'b1;
        mxs = 0; mxe = W - 1; mys = 0; mye = H - 1;
        compare_all("midreset");
        cs_low();
        send_cmd(8'h2C);
        mk = 0;
        send_pixel(16'hC0DE);
        cs_high();
        compare_all("post_reset");

        check("stray frame_done", stray_fd, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
